regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter and scoreboard for the RISC-V integer register file. It shares the register file's single write port between NREQ result producers (ALU, load unit, multiply/divide) using round-robin grant and a valid/ready handshake. It also keeps a per-register pending bit so the issue stage can detect RAW hazards. It sits between the execute/memory units and `register_file`, and drives the write port directly from registers.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- XLEN, 32, data width
- AW, 5, register address width (2**AW architectural registers)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  requester i holds a result
- req_ready  out  NREQ  grant; result i accepted on clk edge where valid[i]&ready[i]
- req_rd  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*XLEN  result, requester i at bits [i*XLEN +: XLEN]
- iss_valid  in  1  issue stage dispatches an instruction that writes iss_rd
- iss_rd  in  AW  destination of issued instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  write address
- rf_wdata  out  XLEN  write data
- busy  out  2**AW  busy[r]=1: write to r outstanding

## Operation
- Round-robin pointer `ptr` (0..NREQ-1).
- Grant: first i with req_valid[i]=1, searching ptr, ptr+1, … mod NREQ. req_ready is one-hot for that i, or all-zero if no requester is valid.
- req_ready depends combinationally on req_valid and ptr only; it never depends on its own requester's data.
- Requesters hold valid/rd/data stable until accepted; deasserting valid before acceptance is illegal.
- On accept of i:
  - ptr <= (i+1) mod NREQ.
  - Output register loads rd/data.
  - rf_we <= (rd != 0). A write to x0 is consumed with rf_we=0, and rf_waddr/rf_wdata still update.
- No accept: rf_we <= 0; ptr, rf_waddr and rf_wdata hold.
- Scoreboard, evaluated on each edge:
  - Set: iss_valid && iss_rd!=0 → busy[iss_rd] <= 1.
  - Clear: accept with rd!=0 → busy[rd] <= 0.
  - Set and clear of the same register on the same edge: set wins (newer producer outstanding).
  - busy[0] is constant 0.
- Duplicate sets, and clears of a non-busy register, are legal no-ops.
- During reset (rst_n low): req_ready forced all-zero, so nothing is accepted.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, ptr=0, req_ready=0.
- Accept on edge N → rf_we/rf_waddr/rf_wdata valid in cycle N+1, and busy clear visible in cycle N+1. Latency 1 cycle.
- Throughput: one write per cycle, sustained. With all requesters valid, each is granted once per NREQ cycles. Worst-case wait is NREQ-1 cycles.
- Pointer wrap: grant to NREQ-1 → ptr=0.
- Reset mid-operation clears the output register and busy; any write in flight is dropped, which is the upstream flush's responsibility.
- The register file must sample rf_* on the same clk edge; no combinational path from req_* to rf_*.

## Structure
- Shared package `rv_pkg`: XLEN, AW, REG_X0 constant (5'd0), and the result record layout (rd + data) used by all execute units.
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: clk, rst_n, req[N], advance.
  - Output: grant[N], one-hot.
  - Owns ptr.
  - Reused later for memory-port arbitration.
- The top level contains the output register, x0 suppression, and the scoreboard.

## Test plan
- Reset then single write: ALU (i=0) valid, rd=5, data=0xDEADBEEF → ready[0]=1 same cycle; next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; then rf_we=0.
- All three valid continuously with distinct rd → grants 0,1,2,0,1,2…; rf_we high every cycle; ptr wraps 2→0.
- x0 write: requester 1 valid, rd=0, data=0x1234 → accepted, next cycle rf_we=0, busy unchanged.
- Scoreboard: iss rd=7 → busy[7]=1; load writes rd=7 → busy[7]=0 the cycle rf_we=1. Repeat with iss rd=7 on the same edge as the accept → busy[7] stays 1.
- Backpressure fairness: requester 0 valid continuously, requester 2 asserted → 2 granted within ≤2 cycles; requester 2 holds data stable until ready[2].
- Mid-stream reset: rst_n low while requests pending → req_ready=0, rf_we=0, busy=0 immediately; after release, first grant goes to the lowest valid index (ptr=0).

Source files
------------

// File: rtl/rv_pkg.sv
// Shared integer-pipeline definitions: widths, x0, and the
// write-back result record produced by every execute unit.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  localparam logic [AW-1:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from ptr upward,
// ptr moves past the winner whenever advance is asserted.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] ptr_nxt;
  logic          found;

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        gidx     = PW'(j);
        found    = 1'b1;
      end
    end
    // Nothing may be accepted while reset is held.
    if (!rst_n) grant = '0;
  end

  assign ptr_nxt = (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between result producers
// and tracks outstanding destination registers for RAW checks.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = rv_pkg::XLEN,
  parameter int AW   = rv_pkg::AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [2**AW-1:0]     busy
);

  import rv_pkg::*;

  localparam int NR = 2**AW;

  logic [NREQ-1:0] grant;
  logic            acc;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            wr_real;
  logic [NR-1:0]   busy_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (acc),
    .grant   (grant)
  );

  assign req_ready = grant;
  assign acc       = |grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_rd   = sel_rd   | req_rd[i*AW +: AW];
        sel_data = sel_data | req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign wr_real = acc && (sel_rd != AW'(REG_X0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr_real;
      if (acc) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end
    end
  end

  // Set is applied after clear so a newer producer stays outstanding.
  always_comb begin
    busy_nxt = busy;
    if (wr_real) busy_nxt[sel_rd] = 1'b0;
    if (iss_valid && iss_rd != AW'(REG_X0))
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed
// grants, write-port values and scoreboard bits.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [31:0]          busy;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(
    .NREQ(NREQ), .XLEN(XLEN), .AW(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [AW-1:0] rd,
                         input logic [XLEN-1:0] d);
    req_valid[i]             = v;
    req_rd[i*AW +: AW]       = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic out_chk(input string tag, input logic we,
                         input logic [AW-1:0] a,
                         input logic [XLEN-1:0] d);
    chk({tag, ".we"},   64'(rf_we),    64'(we));
    chk({tag, ".addr"}, 64'(rf_waddr), 64'(a));
    chk({tag, ".data"}, 64'(rf_wdata), 64'(d));
  endtask

  int rr_seq [6] = '{1, 2, 0, 1, 2, 0};
  logic [AW-1:0]   rr_rd   [3] = '{5'd1, 5'd2, 5'd3};
  logic [XLEN-1:0] rr_data [3] = '{32'h1111_0000,
                                   32'h2222_0000,
                                   32'h3333_0000};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    set_req(0, 1'b1, 5'd3, 32'h5555);
    #3;
    chk("rst.ready", 64'(req_ready), 64'd0);
    out_chk("rst", 1'b0, 5'd0, 32'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    step();
    chk("rst.hold", 64'(rf_we), 64'd0);
    set_req(0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single ALU write
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("single.ready", 64'(req_ready), 64'b001);
    step();
    out_chk("single", 1'b1, 5'd5, 32'hDEADBEEF);
    set_req(0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("single.idle_ready", 64'(req_ready), 64'd0);
    step();
    out_chk("single.after", 1'b0, 5'd5, 32'hDEADBEEF);

    // all valid: ptr is 1 after the grant to 0
    for (int i = 0; i < 3; i++)
      set_req(i, 1'b1, rr_rd[i], rr_data[i]);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr%0d.ready", c), 64'(req_ready),
          64'(1) << rr_seq[c]);
      step();
      out_chk($sformatf("rr%0d", c), 1'b1,
              rr_rd[rr_seq[c]], rr_data[rr_seq[c]]);
    end
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 5'd0, 32'd0);

    // x0 write, ptr=1
    set_req(1, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("x0.ready", 64'(req_ready), 64'b010);
    step();
    out_chk("x0", 1'b0, 5'd0, 32'h1234);
    chk("x0.busy", 64'(busy), 64'd0);
    set_req(1, 1'b0, 5'd0, 32'd0);

    // scoreboard, ptr=2
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    step();
    iss_valid = 1'b0;
    chk("sb.set", 64'(busy), 64'h80);
    set_req(1, 1'b1, 5'd7, 32'hAA);
    step();
    set_req(1, 1'b0, 5'd0, 32'd0);
    out_chk("sb.load", 1'b1, 5'd7, 32'hAA);
    chk("sb.clear", 64'(busy), 64'd0);
    iss_valid = 1'b1;
    step();
    set_req(1, 1'b1, 5'd7, 32'hBB);
    step();
    out_chk("sb.race", 1'b1, 5'd7, 32'hBB);
    chk("sb.setwins", 64'(busy), 64'h80);
    iss_rd = 5'd9;
    set_req(1, 1'b1, 5'd7, 32'hCC);
    step();
    iss_valid = 1'b0;
    set_req(1, 1'b0, 5'd0, 32'd0);
    chk("sb.mixed", 64'(busy), 64'h200);
    iss_valid = 1'b1;
    iss_rd    = 5'd0;
    step();
    iss_valid = 1'b0;
    chk("sb.x0", 64'(busy), 64'h200);

    // fairness: bring ptr to 0 through a grant to 2
    set_req(2, 1'b1, 5'd11, 32'h0B0B);
    step();
    set_req(0, 1'b1, 5'd10, 32'h0A0A);
    set_req(2, 1'b1, 5'd12, 32'h0C0C);
    #1;
    chk("fair.c0", 64'(req_ready), 64'b001);
    step();
    out_chk("fair.a0", 1'b1, 5'd10, 32'h0A0A);
    chk("fair.c1", 64'(req_ready), 64'b100);
    step();
    set_req(2, 1'b0, 5'd0, 32'd0);
    out_chk("fair.a2", 1'b1, 5'd12, 32'h0C0C);

    // mid-stream reset, ptr=0
    set_req(1, 1'b1, 5'd13, 32'h0D0D);
    iss_valid = 1'b1;
    iss_rd    = 5'd4;
    step();
    iss_valid = 1'b0;
    chk("mrst.pre", 64'(busy), 64'h210);
    rst_n = 1'b0;
    #1;
    chk("mrst.ready", 64'(req_ready), 64'd0);
    out_chk("mrst", 1'b0, 5'd0, 32'd0);
    chk("mrst.busy", 64'(busy), 64'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst.first", 64'(req_ready), 64'b001);
    step();
    out_chk("mrst.post", 1'b1, 5'd10, 32'h0A0A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
